// File: rtl/sass_pkg.sv
// sass_pkg: transport states, tempo width and shared tempo constants
package sass_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} transport_t;

    localparam int TEMPO_W = 23;
    localparam int CLK_HZ  = 10_000_000;

    localparam logic [TEMPO_W-1:0] BPM240 = TEMPO_W'(CLK_HZ * 60 / 240 - 1);
    localparam logic [TEMPO_W-1:0] BPM120 = TEMPO_W'(CLK_HZ * 60 / 120 - 1);
    localparam logic [TEMPO_W-1:0] BPM100 = TEMPO_W'(CLK_HZ * 60 / 100 - 1);
    localparam logic [TEMPO_W-1:0] BPM75  = TEMPO_W'(CLK_HZ * 60 / 75 - 1);

endpackage

// File: rtl/beat_timer.sv
// beat_timer: period counter that ticks once count reaches the live tempo
import sass_pkg::*;

module beat_timer #(
    parameter int W = TEMPO_W
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] tempo,
    output logic         tick
);

    logic [W-1:0] count_q, count_d;

    // >= rather than == so a tempo cut below the running count fires at once
    always_comb begin
        tick    = en && (count_q >= tempo);
        count_d = (clr || tick) ? '0 : en ? count_q + 1'b1 : count_q;
    end

    // counter register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) count_q <= '0;
        else        count_q <= count_d;
    end

endmodule

// File: rtl/beat_generator.sv
// beat_generator: play/pause/stop transport driving beat, step and measure pulses
import sass_pkg::*;

module beat_generator #(
    parameter int TEMPO_W = sass_pkg::TEMPO_W,
    parameter int STEPS   = 8,
    parameter int STEP_W  = $clog2(STEPS)
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic [TEMPO_W-1:0] tempo,
    input  logic               play_button,
    input  logic               stop_button,
    output logic               beat_pulse,
    output logic [STEP_W-1:0]  step,
    output logic               measure_pulse,
    output logic               running
);

    transport_t        state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              beat_q, beat_d, measure_q, measure_d, running_q, running_d;
    logic              en, clr, tick, last;

    beat_timer #(.W(TEMPO_W)) u_timer (
        .clk   (clk),
        .n_rst (n_rst),
        .en    (en),
        .clr   (clr),
        .tempo (tempo),
        .tick  (tick)
    );

    // transport decode: stop beats play, play from IDLE gives the downbeat, counting only in RUN
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        en        = 1'b0;
        clr       = 1'b0;
        beat_d    = 1'b0;
        measure_d = 1'b0;
        last      = step_q == STEP_W'(STEPS - 1);
        if (stop_button) begin
            state_d = IDLE;
            clr     = 1'b1;
            step_d  = '0;
        end else if (play_button) begin
            state_d = (state_q == RUN) ? PAUSE : RUN;
            clr     = state_q == IDLE;
            beat_d  = state_q == IDLE;
        end else if (state_q == RUN) begin
            en        = 1'b1;
            beat_d    = tick;
            measure_d = tick && last;
            step_d    = !tick ? step_q : last ? '0 : step_q + 1'b1;
        end
        running_d = state_d == RUN;
    end

    // state and output registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            step_q    <= '0;
            beat_q    <= 1'b0;
            measure_q <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            beat_q    <= beat_d;
            measure_q <= measure_d;
            running_q <= running_d;
        end
    end

    assign beat_pulse    = beat_q;
    assign step          = step_q;
    assign measure_pulse = measure_q;
    assign running       = running_q;

endmodule

// File: tb/tb_beat_generator.sv
// tb_beat_generator: directed and random transport sequences checked against a rule-level model
module tb_beat_generator;

    localparam int TW    = 23;
    localparam int STEPS = 8;
    localparam int SW    = 3;

    logic          clk = 1'b0;
    logic          n_rst = 1'b0;
    logic [TW-1:0] tempo = '0;
    logic          play_button = 1'b0;
    logic          stop_button = 1'b0;
    logic          beat_pulse, measure_pulse, running;
    logic [SW-1:0] step;

    int vectors = 0;
    int errors  = 0;

    // model: mode 0=idle 1=run 2=pause
    int   m_mode = 0;
    int   m_cnt  = 0;
    int   m_stp  = 0;
    logic m_beat = 1'b0;
    logic m_meas = 1'b0;
    int   beats  = 0;
    int   meas   = 0;

    beat_generator dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .tempo         (tempo),
        .play_button   (play_button),
        .stop_button   (stop_button),
        .beat_pulse    (beat_pulse),
        .step          (step),
        .measure_pulse (measure_pulse),
        .running       (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".beat"}, int'(beat_pulse), int'(m_beat));
        check({tag, ".step"}, int'(step), m_stp);
        check({tag, ".meas"}, int'(measure_pulse), int'(m_meas));
        check({tag, ".run"}, int'(running), int'(m_mode == 1));
    endtask

    task automatic model_reset();
        m_mode = 0; m_cnt = 0; m_stp = 0; m_beat = 1'b0; m_meas = 1'b0;
    endtask

    task automatic model_edge(input logic p, input logic s, input int t);
        m_beat = 1'b0;
        m_meas = 1'b0;
        if (s) begin
            m_mode = 0; m_cnt = 0; m_stp = 0;
        end else if (p) begin
            if (m_mode == 0) begin
                m_mode = 1; m_cnt = 0; m_beat = 1'b1;
            end else m_mode = (m_mode == 1) ? 2 : 1;
        end else if (m_mode == 1) begin
            if (m_cnt >= t) begin
                m_cnt  = 0;
                m_beat = 1'b1;
                m_meas = (m_stp == STEPS - 1);
                m_stp  = (m_stp + 1) % STEPS;
            end else m_cnt++;
        end
    endtask

    // one clock: drive buttons, advance the model, check outputs 1 time unit after the edge
    task automatic cyc(input string tag, input logic p, input logic s, input int t);
        play_button = p;
        stop_button = s;
        tempo = TW'(t);
        @(posedge clk);
        model_edge(p, s, t);
        #1;
        check_all(tag);
        beats += int'(beat_pulse);
        meas  += int'(measure_pulse);
        play_button = 1'b0;
        stop_button = 1'b0;
    endtask

    initial begin
        int t, n;
        bit seen;
        // reset values
        tempo = TW'(3);
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        check_all("reset");
        #3 n_rst = 1'b1;
        beats = 0;
        for (int i = 0; i < 20; i++) cyc("idle", 1'b0, 1'b0, 3);
        check("idle_beats", beats, 0);

        // play at tempo 3 across a measure wrap
        beats = 0; meas = 0;
        cyc("play3", 1'b1, 1'b0, 3);
        for (int i = 0; i < 32; i++) cyc("run3", 1'b0, 1'b0, 3);
        check("run3_beats", beats, 9);
        check("run3_meas", meas, 1);
        cyc("stop3", 1'b0, 1'b1, 3);

        // pause/resume at tempo 9
        cyc("play9", 1'b1, 1'b0, 9);
        for (int i = 0; i < 5; i++) cyc("run9", 1'b0, 1'b0, 9);
        cyc("pause", 1'b1, 1'b0, 9);
        beats = 0;
        for (int i = 0; i < 20; i++) cyc("paused", 1'b0, 1'b0, 9);
        check("paused_beats", beats, 0);
        cyc("resume", 1'b1, 1'b0, 9);
        n = 0; seen = 0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            cyc("resumed", 1'b0, 1'b0, 9);
            if (beat_pulse) begin seen = 1; n = i; end
        end
        check("resume_latency", n, 5);
        cyc("stop9", 1'b0, 1'b1, 9);

        // tempo shrink mid-beat, then tempo 0
        cyc("play_s", 1'b1, 1'b0, 9);
        for (int i = 0; i < 7; i++) cyc("pre_shrink", 1'b0, 1'b0, 9);
        cyc("shrink", 1'b0, 1'b0, 2);
        check("shrink_beat", int'(beat_pulse), 1);
        for (int i = 0; i < 9; i++) cyc("t2", 1'b0, 1'b0, 2);
        beats = 0;
        for (int i = 0; i < 10; i++) cyc("t0", 1'b0, 1'b0, 0);
        check("t0_beats", beats, 10);
        cyc("stop_s", 1'b0, 1'b1, 0);

        // simultaneous play+stop at step 5
        cyc("play_ps", 1'b1, 1'b0, 0);
        for (int i = 0; i < 5; i++) cyc("run_ps", 1'b0, 1'b0, 0);
        check("step5", int'(step), 5);
        cyc("play_stop", 1'b1, 1'b1, 0);
        cyc("replay", 1'b1, 1'b0, 0);
        check("downbeat", int'(beat_pulse), 1);
        cyc("stop_r", 1'b0, 1'b1, 0);

        // async reset mid-beat at step 3
        cyc("play_ar", 1'b1, 1'b0, 3);
        for (int i = 0; i < 14; i++) cyc("run_ar", 1'b0, 1'b0, 3);
        check("step3", int'(step), 3);
        #2 n_rst = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        #3 n_rst = 1'b1;
        beats = 0;
        for (int i = 0; i < 10; i++) cyc("post_rst", 1'b0, 1'b0, 3);
        check("post_rst_beats", beats, 0);

        // random transport and tempo churn
        t = 4;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) t = $urandom_range(7);
            cyc("rand", $urandom_range(19) == 0, $urandom_range(59) == 0, t);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/beat_generator.md
Name: beat_generator

Overview:
- Sits directly downstream of the tempo selector.
- Consumes the 23-bit tempo period (clk cycles per beat, minus one) and produces the beat_pulse that drives the sequencer.
- Also produces the current step index within a measure and a measure-wrap pulse.
- A play/pause/stop state machine gates counting, so the sequencer can be started, paused and rewound from the user buttons.

Parameters:
- TEMPO_W, 23, width of the tempo period input.
- STEPS, 8, steps per measure (must be ≥2).
- STEP_W, $clog2(STEPS), width of the step output.

Ports:
- clk  input  1  system clock.
- n_rst  input  1  reset, asynchronous, active-low.
- tempo  input  TEMPO_W  beat period; one beat every tempo+1 clk cycles.
- play_button  input  1  single-cycle pulse: start / pause / resume toggle.
- stop_button  input  1  single-cycle pulse: stop and rewind to step 0.
- beat_pulse  output  1  one-cycle pulse per beat.
- step  output  STEP_W  current step index, 0..STEPS-1.
- measure_pulse  output  1  one-cycle pulse when step wraps STEPS-1 -> 0.
- running  output  1  high while in RUN.

Behaviour:
- Reset (n_rst=0, async):
  - state=IDLE, count=0, step=0.
  - beat_pulse=0, measure_pulse=0, running=0.
- All outputs are registered. beat_pulse, step, measure_pulse and running change on the same clk edge as the event that causes them.
- States are IDLE, RUN and PAUSE. Transitions on the clk edge:
  - stop_button=1 (any state) -> IDLE; count<=0, step<=0. stop wins over a simultaneous play_button.
  - IDLE + play_button -> RUN; count<=0; beat_pulse<=1 with step held at 0. This is the immediate downbeat.
  - RUN + play_button -> PAUSE; count and step hold; no beat this edge, even if count ≥ tempo.
  - PAUSE + play_button -> RUN; count resumes from its held value; no extra downbeat.
  - No button -> stay in the current state.
- Counting in RUN (no button active):
  - count < tempo: count<=count+1, beat_pulse<=0.
  - count ≥ tempo: count<=0, beat_pulse<=1, step<=(step==STEPS-1)?0:step+1.
  - measure_pulse<=1 iff this beat wraps step from STEPS-1 to 0.
- Beat period is exactly tempo+1 cycles while tempo is stable.
- tempo=0: a beat every cycle in RUN.
- Tempo changes mid-beat:
  - tempo is sampled every cycle; no latching.
  - If the new tempo < count, the ≥ compare fires a beat on the next RUN edge. The counter never runs to 2^TEMPO_W.
  - If the new tempo > count, the current beat stretches to the new period.
- count is TEMPO_W bits and never exceeds the maximum tempo value.
- beat_pulse and measure_pulse are 0 in IDLE and PAUSE except on the IDLE->RUN downbeat edge. measure_pulse is never set on the downbeat.
- running=1 iff the next state is RUN.
- Reset mid-beat aborts immediately. No pulse is emitted on reset release.

Decomposition:
- Shared package sass_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, PAUSE} transport_t.
  - Tempo constants BPM240/BPM120/BPM100/BPM75, so the tempo selector and this block share one definition.
  - TEMPO_W localparam.
- One sub-module, beat_timer:
  - The period counter plus ≥ compare.
  - Inputs: clk, n_rst, en, clr, tempo.
  - Output: tick, combinational, asserted when en && count ≥ tempo.
- The top level holds the FSM, step counter and output registers.

Test Plan:
- Reset values: hold n_rst=0 with tempo=3 -> all outputs 0, step=0; release with no buttons for 20 cycles -> no beat_pulse.
- Play from IDLE, tempo=3 -> beat_pulse on the play edge (step=0), then every 4 cycles with step 1,2,…,7,0; measure_pulse coincides only with the 7->0 beat; 9 beats total across the wrap.
- Pause/resume, tempo=9 -> play, wait 5 cycles, pause for 20 cycles: no pulses and step held. Resume: next beat arrives 5 cycles after resume, not 10. No extra pulse on resume.
- Tempo shrink, tempo=9 with count reaching 7 -> drive tempo=2: beat on the next edge, then every 3 cycles. Tempo=0 -> beat_pulse high every cycle.
- Simultaneous play+stop while in RUN at step=5 -> IDLE, step=0, running=0, no beat. A subsequent play gives the downbeat at step 0.
- Async reset asserted mid-beat in RUN (step=3) -> outputs clear without waiting for clk. After release, the block stays in IDLE until play.
